// File: rtl/sram_seq_pkg.sv
// Shared types and defaults for the SRAM access sequencer.
// Contents:
//   seq_state_t   - sequencer state encoding
//   strobe_t      - bundle of active-low SRAM strobes
//   STROBES_IDLE  - all strobes deasserted
//   wait_cnt_w()  - wait-counter width for a given pair of wait-state settings
package sram_seq_pkg;

  localparam int ADDR_W_DEF     = 20;
  localparam int DATA_W_DEF     = 16;
  localparam int READ_WAIT_DEF  = 2;
  localparam int WRITE_WAIT_DEF = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_ACCESS = 3'd1,
    WR_SETUP  = 3'd2,
    WR_PULSE  = 3'd3,
    WR_HOLD   = 3'd4,
    RESP      = 3'd5
  } seq_state_t;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic ub_n;
    logic lb_n;
  } strobe_t;

  localparam strobe_t STROBES_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
                                       ub_n: 1'b1, lb_n: 1'b1};

  // Counter must hold the larger of the two wait settings.
  function automatic int wait_cnt_w(input int rd_wait, input int wr_wait);
    return $clog2(((rd_wait > wr_wait) ? rd_wait : wr_wait) + 1);
  endfunction

endpackage

// File: rtl/sram_access_sequencer_if.sv
// CPU-side request/response bus of the SRAM access sequencer.
// Signals:
//   req_valid / req_ready  request handshake
//   req_we                 1 = write, 0 = read
//   req_addr / req_wdata   word address and write data
//   rsp_valid              one-cycle completion pulse
//   rsp_rdata              data of the most recent read
// Modports: master = requester (CPU), slave = sequencer.
interface sram_access_sequencer_if
  import sram_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram_access_sequencer_wait_counter.sv
// Down-counter timing the OE/WE low phases of an SRAM access.
// Ports:
//   Clk, Reset  clock and synchronous active-high reset
//   load        load load_val (takes priority over dec)
//   load_val    number of cycles of the coming phase
//   dec         count down one step; holds at zero
//   last        current cycle is the final one of the phase (count == 1)
module sram_wait_counter #(
  parameter int CNT_W = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/sram_access_sequencer.sv
// Self-timed SRAM access engine: turns one-word CPU requests into sequenced
// active-low SRAM strobes with programmable wait states.
// Ports:
//   Clk, Reset          clock, synchronous active-high reset
//   bus                 CPU request/response bus (slave side)
//   ADDR                SRAM address (holds last accepted address)
//   CE_N/OE_N/WE_N      chip enable, output enable, write enable
//   UB_N/LB_N           byte lanes, always follow CE_N (word access only)
//   dq_out, dq_oe       write data and its pin-driver enable for the top level
//   dq_in               data read back from the SRAM pins
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | ready for a request, strobes off
// RD_ACCESS | CE/OE low for READ_WAIT cycles, dq_in captured on the last
// WR_SETUP  | CE low and data driven, WE still high (address/data setup)
// WR_PULSE  | WE low for WRITE_WAIT cycles
// WR_HOLD   | WE back high, data still driven (hold past WE rising edge)
// RESP      | one-cycle rsp_valid pulse, not ready
module sram_access_sequencer
  import sram_seq_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int READ_WAIT  = READ_WAIT_DEF,
  parameter int WRITE_WAIT = WRITE_WAIT_DEF
) (
  input  logic                   Clk,
  input  logic                   Reset,
  sram_access_sequencer_if.slave bus,
  output logic [ADDR_W-1:0]      ADDR,
  output logic                   CE_N,
  output logic                   OE_N,
  output logic                   WE_N,
  output logic                   UB_N,
  output logic                   LB_N,
  output logic [DATA_W-1:0]      dq_out,
  output logic                   dq_oe,
  input  logic [DATA_W-1:0]      dq_in
);

  localparam int CNT_W = wait_cnt_w(READ_WAIT, WRITE_WAIT);

  localparam logic [2:0] S_IDLE      = IDLE;
  localparam logic [2:0] S_RD_ACCESS = RD_ACCESS;
  localparam logic [2:0] S_WR_SETUP  = WR_SETUP;
  localparam logic [2:0] S_WR_PULSE  = WR_PULSE;
  localparam logic [2:0] S_WR_HOLD   = WR_HOLD;
  localparam logic [2:0] S_RESP      = RESP;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              accept;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              cnt_dec;
  logic              cnt_last;
  strobe_t           strb;

  assign accept       = (state == S_IDLE) && bus.req_valid;
  // Loaded at accept; WR_SETUP does not decrement, so the write count is
  // still intact when WR_PULSE begins.
  assign cnt_load_val = bus.req_we ? CNT_W'(WRITE_WAIT) : CNT_W'(READ_WAIT);
  assign cnt_dec      = (state == S_RD_ACCESS) || (state == S_WR_PULSE);

  sram_wait_counter #(.CNT_W(CNT_W)) u_wait_counter (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (accept),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (bus.req_valid) state_nxt = bus.req_we ? S_WR_SETUP : S_RD_ACCESS;
      S_RD_ACCESS: if (cnt_last) state_nxt = S_RESP;
      S_WR_SETUP:  state_nxt = S_WR_PULSE;
      S_WR_PULSE:  if (cnt_last) state_nxt = S_WR_HOLD;
      S_WR_HOLD:   state_nxt = S_RESP;
      S_RESP:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if ((state == S_RD_ACCESS) && cnt_last) begin
        rdata_q <= dq_in;
      end
    end
  end

  // Strobes decode the state register only, so no request input can reach
  // the SRAM pins combinationally. OE and WE are never low in the same state,
  // and OE is never low while dq_oe is set.
  always_comb begin
    strb  = STROBES_IDLE;
    dq_oe = 1'b0;
    case (state)
      S_RD_ACCESS: begin
        strb.ce_n = 1'b0;
        strb.oe_n = 1'b0;
      end
      S_WR_SETUP, S_WR_HOLD: begin
        strb.ce_n = 1'b0;
        dq_oe     = 1'b1;
      end
      S_WR_PULSE: begin
        strb.ce_n = 1'b0;
        strb.we_n = 1'b0;
        dq_oe     = 1'b1;
      end
      default: ;
    endcase
    strb.ub_n = strb.ce_n;
    strb.lb_n = strb.ce_n;
  end

  assign CE_N   = strb.ce_n;
  assign OE_N   = strb.oe_n;
  assign WE_N   = strb.we_n;
  assign UB_N   = strb.ub_n;
  assign LB_N   = strb.lb_n;
  assign ADDR   = addr_q;
  assign dq_out = wdata_q;

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_sram_access_sequencer.sv
module tb_sram_access_sequencer;
  import sram_seq_pkg::*;

  localparam int AW   = 20;
  localparam int DW   = 16;
  localparam int RW_A = 2;
  localparam int WW_A = 2;
  localparam int RW_B = 1;
  localparam int WW_B = 4;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  sram_access_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  sram_access_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  logic [AW-1:0] addr_a, addr_b;
  logic ce_a, oe_a, we_a, ub_a, lb_a, dqoe_a;
  logic ce_b, oe_b, we_b, ub_b, lb_b, dqoe_b;
  logic [DW-1:0] dqo_a, dqi_a, dqo_b, dqi_b;

  sram_access_sequencer #(.ADDR_W(AW), .DATA_W(DW), .READ_WAIT(RW_A), .WRITE_WAIT(WW_A)) dut_a (
    .Clk(Clk), .Reset(Reset), .bus(bus_a), .ADDR(addr_a),
    .CE_N(ce_a), .OE_N(oe_a), .WE_N(we_a), .UB_N(ub_a), .LB_N(lb_a),
    .dq_out(dqo_a), .dq_oe(dqoe_a), .dq_in(dqi_a)
  );

  sram_access_sequencer #(.ADDR_W(AW), .DATA_W(DW), .READ_WAIT(RW_B), .WRITE_WAIT(WW_B)) dut_b (
    .Clk(Clk), .Reset(Reset), .bus(bus_b), .ADDR(addr_b),
    .CE_N(ce_b), .OE_N(oe_b), .WE_N(we_b), .UB_N(ub_b), .LB_N(lb_b),
    .dq_out(dqo_b), .dq_oe(dqoe_b), .dq_in(dqi_b)
  );

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'h12) ? 16'h3003 : {8'hA5, a};
  endfunction

  // Behavioural SRAM for DUT A: stores while CE and WE are low, drives only
  // while CE and OE are low, junk otherwise.
  logic [15:0] mem_a [256];
  bit mem_init = 1'b0;
  always @(posedge Clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= init_val(8'(i));
      mem_init <= 1'b1;
    end else if (!ce_a && !we_a) begin
      mem_a[addr_a[7:0]] <= dqo_a;
    end
  end
  assign dqi_a = (!ce_a && !oe_a) ? mem_a[addr_a[7:0]] : 16'h5A5A;
  assign dqi_b = (!ce_b && !oe_b) ? init_val(addr_b[7:0]) : 16'h5A5A;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference model for DUT A: one outstanding transaction, strobes derived
  // from the cycle offset since the accept edge.
  typedef struct {
    int          start;
    int          due;
    bit          is_rd;
    logic [15:0] rdata;
  } exp_t;

  exp_t        q[$];
  logic [15:0] ref_mem [int];
  logic [AW-1:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_rdata = '0;
  int          n_rsp = 0;

  always @(negedge Clk) begin
    bit   busy;
    int   d;
    logic e_ce, e_oe, e_we, e_dqoe, e_rsp;
    exp_t e;
    if (Reset) begin
      q.delete();
      m_addr  = '0;
      m_wdata = '0;
      m_rdata = '0;
    end else begin
      busy = (q.size() != 0);
      e_ce = 1'b1; e_oe = 1'b1; e_we = 1'b1; e_dqoe = 1'b0; e_rsp = 1'b0;
      if (busy) begin
        d = cyc - q[0].start;
        if (cyc == q[0].due) e_rsp = 1'b1;
        else if (q[0].is_rd) begin
          e_ce = 1'b0; e_oe = 1'b0;
        end else begin
          e_ce = 1'b0; e_dqoe = 1'b1;
          if (d >= 1 && d <= WW_A) e_we = 1'b0;
        end
      end
      chk("a_req_ready", 32'(bus_a.req_ready), 32'(!busy));
      chk("a_rsp_valid", 32'(bus_a.rsp_valid), 32'(e_rsp));
      chk("a_ce_n", 32'(ce_a), 32'(e_ce));
      chk("a_oe_n", 32'(oe_a), 32'(e_oe));
      chk("a_we_n", 32'(we_a), 32'(e_we));
      chk("a_ub_n", 32'(ub_a), 32'(e_ce));
      chk("a_lb_n", 32'(lb_a), 32'(e_ce));
      chk("a_dq_oe", 32'(dqoe_a), 32'(e_dqoe));
      chk("a_addr", 32'(addr_a), 32'(m_addr));
      if (e_dqoe) chk("a_dq_out", 32'(dqo_a), 32'(m_wdata));
      if (e_rsp) begin
        if (q[0].is_rd) m_rdata = q[0].rdata;
        void'(q.pop_front());
      end
      chk("a_rsp_rdata", 32'(bus_a.rsp_rdata), 32'(m_rdata));
      if (bus_a.rsp_valid) n_rsp++;
      if (!busy && bus_a.req_valid) begin
        e.start = cyc + 1;
        e.is_rd = !bus_a.req_we;
        e.due   = e.start + (e.is_rd ? RW_A : WW_A + 2);
        e.rdata = '0;
        if (e.is_rd)
          e.rdata = ref_mem.exists(int'(bus_a.req_addr)) ? ref_mem[int'(bus_a.req_addr)]
                                                         : init_val(bus_a.req_addr[7:0]);
        else
          ref_mem[int'(bus_a.req_addr)] = bus_a.req_wdata;
        m_addr  = bus_a.req_addr;
        m_wdata = bus_a.req_wdata;
        q.push_back(e);
      end
    end
  end

  // Contention invariants on DUT B.
  always @(negedge Clk) begin
    if (!Reset) begin
      chk("b_oe_with_dq_oe", 32'(!oe_b && dqoe_b), 32'(0));
      chk("b_oe_with_we", 32'(!oe_b && !we_b), 32'(0));
      chk("b_ub_lb_follow_ce", 32'({ub_b, lb_b}), 32'({ce_b, ce_b}));
    end
  end

  // Selected DUT view for the transaction task.
  bit sel_b = 1'b0;
  logic s_ready, s_rsp, s_ce, s_oe, s_we, s_dqoe;
  logic [DW-1:0] s_rdata, s_dqo;
  logic [AW-1:0] s_addr;
  assign s_ready = sel_b ? bus_b.req_ready : bus_a.req_ready;
  assign s_rsp   = sel_b ? bus_b.rsp_valid : bus_a.rsp_valid;
  assign s_rdata = sel_b ? bus_b.rsp_rdata : bus_a.rsp_rdata;
  assign s_ce    = sel_b ? ce_b : ce_a;
  assign s_oe    = sel_b ? oe_b : oe_a;
  assign s_we    = sel_b ? we_b : we_a;
  assign s_dqoe  = sel_b ? dqoe_b : dqoe_a;
  assign s_dqo   = sel_b ? dqo_b : dqo_a;
  assign s_addr  = sel_b ? addr_b : addr_a;

  task automatic drive(input bit sel, input logic v, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!sel) begin
      bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_addr = a; bus_a.req_wdata = d;
    end else begin
      bus_b.req_valid = v; bus_b.req_we = we; bus_b.req_addr = a; bus_b.req_wdata = d;
    end
  endtask

  typedef struct {
    logic [15:0] rd;
    int oe_lo, we_lo, dqoe_hi, rsp_off, nrsp;
    bit addr_ok, dq_ok;
  } meas_t;

  task automatic do_txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output meas_t m);
    int n = 0;
    bit acc = 1'b0;
    m.rd = '0; m.oe_lo = 0; m.we_lo = 0; m.dqoe_hi = 0; m.rsp_off = -1; m.nrsp = 0;
    m.addr_ok = 1'b1; m.dq_ok = 1'b1;
    @(posedge Clk); #1;
    drive(sel_b, 1'b1, we, a, d);
    while (!acc && n < 20) begin
      @(negedge Clk);
      acc = s_ready;
      n++;
    end
    chk("txn_accepted", 32'(acc), 32'(1));
    @(posedge Clk); #1;
    drive(sel_b, 1'b0, we, a, d);
    for (int i = 0; i < 14; i++) begin
      @(negedge Clk);
      if (!s_oe) m.oe_lo++;
      if (!s_we) m.we_lo++;
      if (s_dqoe) m.dqoe_hi++;
      if (!s_ce && s_addr !== a) m.addr_ok = 1'b0;
      if (s_dqoe && s_dqo !== d) m.dq_ok = 1'b0;
      if (s_rsp) begin
        m.nrsp++;
        m.rd = s_rdata;
        if (m.rsp_off < 0) m.rsp_off = i;
      end
    end
  endtask

  typedef struct {
    bit          we;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    int          exp_oe_lo, exp_we_lo, exp_dqoe_hi, exp_rsp_off;
  } vec_t;

  vec_t  vecs[6];
  meas_t m;

  initial begin
    bit acc;
    bit we_t;
    int n, cnt_acc, rsp0;

    // {we, addr, wdata, expected rsp_rdata, OE-low, WE-low, dq_oe-high, rsp offset}
    vecs[0] = '{1'b0, 20'h00012, 16'h0000, 16'h3003, RW_A, 0, 0, RW_A};
    vecs[1] = '{1'b1, 20'h0001F, 16'hBEEF, 16'h3003, 0, WW_A, WW_A + 2, WW_A + 2};
    vecs[2] = '{1'b0, 20'h0001F, 16'h0000, 16'hBEEF, RW_A, 0, 0, RW_A};
    vecs[3] = '{1'b1, 20'h00012, 16'h1234, 16'hBEEF, 0, WW_A, WW_A + 2, WW_A + 2};
    vecs[4] = '{1'b0, 20'h00012, 16'h0000, 16'h1234, RW_A, 0, 0, RW_A};
    vecs[5] = '{1'b0, 20'h00005, 16'h0000, 16'hA505, RW_A, 0, 0, RW_A};

    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("rst_req_ready", 32'(bus_a.req_ready), 32'(1));
    chk("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'(0));
    chk("rst_rsp_rdata", 32'(bus_a.rsp_rdata), 32'(0));
    chk("rst_addr", 32'(addr_a), 32'(0));
    chk("rst_dq_out", 32'(dqo_a), 32'(0));
    chk("rst_dq_oe", 32'(dqoe_a), 32'(0));
    chk("rst_strobes", 32'({ce_a, oe_a, we_a, ub_a, lb_a}), 32'(5'b11111));
    chk("rst_b_strobes", 32'({ce_b, oe_b, we_b, dqoe_b}), 32'(4'b1110));

    // Table-driven single transactions on DUT A.
    for (int v = 0; v < 6; v++) begin
      do_txn(vecs[v].we, vecs[v].addr, vecs[v].wdata, m);
      chk($sformatf("vec%0d_rsp_rdata", v), 32'(m.rd), 32'(vecs[v].exp_rd));
      chk($sformatf("vec%0d_oe_low_cycles", v), 32'(m.oe_lo), 32'(vecs[v].exp_oe_lo));
      chk($sformatf("vec%0d_we_low_cycles", v), 32'(m.we_lo), 32'(vecs[v].exp_we_lo));
      chk($sformatf("vec%0d_dq_oe_cycles", v), 32'(m.dqoe_hi), 32'(vecs[v].exp_dqoe_hi));
      chk($sformatf("vec%0d_rsp_offset", v), 32'(m.rsp_off), 32'(vecs[v].exp_rsp_off));
      chk($sformatf("vec%0d_rsp_pulses", v), 32'(m.nrsp), 32'(1));
      chk($sformatf("vec%0d_addr_stable", v), 32'(m.addr_ok), 32'(1));
      chk($sformatf("vec%0d_dq_out", v), 32'(m.dq_ok), 32'(1));
    end

    // req_valid held high, alternating read/write: reads take RW_A+2 cycles,
    // writes WW_A+4, so in 60 cycles accepts land at offsets 0,4,10,14,...,54.
    rsp0 = n_rsp;
    cnt_acc = 0;
    we_t = 1'b0;
    @(posedge Clk); #1;
    drive(1'b0, 1'b1, we_t, 20'h3, 16'h1111);
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      acc = bus_a.req_ready;
      @(posedge Clk); #1;
      if (acc) begin
        cnt_acc++;
        we_t = !we_t;
        drive(1'b0, 1'b1, we_t, 20'(i & 7), 16'($urandom));
      end
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (12) @(negedge Clk);
    chk("alt_accept_count", 32'(cnt_acc), 32'(12));
    chk("alt_rsp_count", 32'(n_rsp - rsp0), 32'(12));

    // Reset during the second WE-low cycle of a write.
    @(posedge Clk); #1;
    drive(1'b0, 1'b1, 1'b1, 20'h0001F, 16'h5555);
    n = 0; acc = 1'b0;
    while (!acc && n < 20) begin
      @(negedge Clk);
      acc = bus_a.req_ready;
      n++;
    end
    chk("rst_mid_accepted", 32'(acc), 32'(1));
    @(posedge Clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(negedge Clk);
    chk("rst_mid_in_pulse2", 32'(we_a), 32'(0));
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_mid_strobes", 32'({ce_a, oe_a, we_a, ub_a, lb_a}), 32'(5'b11111));
    chk("rst_mid_dq_oe", 32'(dqoe_a), 32'(0));
    chk("rst_mid_ready", 32'(bus_a.req_ready), 32'(1));
    rsp0 = n_rsp;
    repeat (5) @(negedge Clk);
    chk("rst_mid_no_rsp", 32'(n_rsp - rsp0), 32'(0));
    // The SRAM model latched the data during the WE pulse that did occur.
    do_txn(1'b0, 20'h0001F, 16'h0000, m);
    chk("rst_mid_read_rdata", 32'(m.rd), 32'(16'h5555));
    chk("rst_mid_read_rsp", 32'(m.nrsp), 32'(1));

    // Random stream against the reference model.
    rsp0 = n_rsp;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      acc = bus_a.req_valid && bus_a.req_ready;
      @(posedge Clk); #1;
      if (acc || !bus_a.req_valid)
        drive(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              20'($urandom_range(0, 7)), 16'($urandom));
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (12) @(negedge Clk);
    chk("random_rsp_seen", 32'(n_rsp - rsp0 > 0), 32'(1));

    // DUT B: READ_WAIT=1, WRITE_WAIT=4.
    sel_b = 1'b1;
    do_txn(1'b0, 20'h00012, 16'h0000, m);
    chk("b_rd_rdata", 32'(m.rd), 32'(16'h3003));
    chk("b_rd_oe_low_cycles", 32'(m.oe_lo), 32'(RW_B));
    chk("b_rd_we_low_cycles", 32'(m.we_lo), 32'(0));
    chk("b_rd_rsp_offset", 32'(m.rsp_off), 32'(RW_B));
    chk("b_rd_rsp_pulses", 32'(m.nrsp), 32'(1));
    do_txn(1'b1, 20'h00007, 16'hCAFE, m);
    chk("b_wr_rdata_kept", 32'(m.rd), 32'(16'h3003));
    chk("b_wr_we_low_cycles", 32'(m.we_lo), 32'(WW_B));
    chk("b_wr_oe_low_cycles", 32'(m.oe_lo), 32'(0));
    chk("b_wr_dq_oe_cycles", 32'(m.dqoe_hi), 32'(WW_B + 2));
    chk("b_wr_rsp_offset", 32'(m.rsp_off), 32'(WW_B + 2));
    chk("b_wr_rsp_pulses", 32'(m.nrsp), 32'(1));
    chk("b_wr_addr_stable", 32'(m.addr_ok), 32'(1));
    chk("b_wr_dq_out", 32'(m.dq_ok), 32'(1));
    sel_b = 1'b0;

    repeat (2) @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
